// File: rtl/ipl_pkg.sv
// Shared types and the combinational priority rule for the IPL encoder.
// The code struct mirrors the three output groups of a 74F148: {_A, _GS, _EO}.
package ipl_pkg;

    typedef struct packed {
        logic [2:0] a;
        logic       gs;
        logic       eo;
    } ipl_code_t;

    localparam ipl_code_t CODE_DISABLED = '{a: 3'b111, gs: 1'b1, eo: 1'b1};
    localparam ipl_code_t CODE_IDLE     = '{a: 3'b111, gs: 1'b1, eo: 1'b0};

    // Ascending scan so the highest active index is the last one written.
    function automatic ipl_code_t prio_encode(input logic [7:0] i_s, input logic ei_s);
        ipl_code_t code;
        code = ei_s ? CODE_DISABLED : CODE_IDLE;
        if (!ei_s) begin
            for (int k = 0; k < 8; k++) begin
                if (!i_s[k]) begin
                    code = '{a: ~3'(k), gs: 1'b0, eo: 1'b1};
                end
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/ipl_priority_encoder_if.sv
// Request/IPL signal bundle between the interrupt sources and the CPU IPL pins.
// All signals are active-low except the CHG strobe.
interface ipl_priority_encoder_if;
    logic [7:0] _I;
    logic       _EI;
    logic       _HOLD;
    logic [2:0] _A;
    logic       _GS;
    logic       _EO;
    logic       CHG;

    modport master (output _I, _EI, _HOLD, input _A, _GS, _EO, CHG);
    modport slave  (input _I, _EI, _HOLD, output _A, _GS, _EO, CHG);
endinterface

// File: rtl/sync_chain.sv
// Multi-bit flop-chain synchroniser for asynchronous active-low lines.
// Synchronous reset drives every stage to all-ones, i.e. every line inactive.
module sync_chain #(
    parameter int WIDTH  = 9,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '1;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's old value, forming a true shift chain.
            stage_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ipl_priority_encoder.sv
// Registered 74F148-style 8-to-3 active-low priority encoder with input
// synchronisers, a FILTER-cycle stability filter and an output hold.
module ipl_priority_encoder
    import ipl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2
) (
    input logic                    CLK,
    input logic                    RST,
    ipl_priority_encoder_if.slave  bus
);

    localparam int            CW   = $clog2(FILTER + 1);
    localparam logic [CW-1:0] FILT = CW'(FILTER);

    logic [8:0]    sync_d;
    logic [8:0]    sync_q;
    ipl_code_t     cand;
    ipl_code_t     hist_q;
    ipl_code_t     out_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;
    logic          chg_d;
    logic          chg_q;

    assign sync_d = {bus._EI, bus._I};

    sync_chain #(
        .WIDTH  (9),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (sync_d),
        .q_o   (sync_q)
    );

    // cnt_d is the stable count including the current edge; it saturates at FILTER.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cand  = prio_encode(sync_q[7:0], sync_q[8]);
        cnt_d = cnt_q;
        if (cand != hist_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != FILT) begin
            cnt_d = cnt_q + CW'(1);
        end
        chg_d = (cnt_d == FILT) && bus._HOLD && (cand != out_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_q <= CODE_DISABLED;
            cnt_q  <= '0;
            out_q  <= CODE_DISABLED;
            chg_q  <= 1'b0;
        end else begin
            hist_q <= cand;
            cnt_q  <= cnt_d;
            chg_q  <= chg_d;
            if (chg_d) begin
                out_q <= cand;
            end
        end
    end

    assign bus._A   = out_q.a;
    assign bus._GS  = out_q.gs;
    assign bus._EO  = out_q.eo;
    assign bus.CHG  = chg_q;

endmodule

// File: tb/tb_ipl_priority_encoder.sv
// Self-checking bench for ipl_priority_encoder: directed plan plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_ipl_priority_encoder;

    localparam int S = 2;
    localparam int F = 2;

    logic CLK;
    logic RST;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   chg_cnt;

    ipl_priority_encoder_if bus ();

    ipl_priority_encoder #(
        .SYNC_STAGES (S),
        .FILTER      (F)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: inputs delayed S edges through a queue, then the last
    // F candidates must all agree before a load is allowed.
    logic [8:0] m_inq[$];
    logic [4:0] m_cands[$];
    logic [4:0] m_out = 5'b11111;
    logic       m_chg = 1'b0;

    function automatic logic [4:0] ref_code(input logic ei, input logic [7:0] i);
        int x;
        int n;
        if (ei) return 5'b111_1_1;
        if (i == 8'hFF) return 5'b111_1_0;
        x = int'(~i) & 255;
        n = $clog2(x + 1) - 1;
        return {3'(7 - n), 2'b01};
    endfunction

    task automatic model_edge();
        logic [8:0] s;
        logic [4:0] c;
        logic       stable;
        if (RST) begin
            m_inq = {};
            for (int k = 0; k < S; k++) m_inq.push_back(9'h1FF);
            m_cands = {};
            m_out = 5'b11111;
            m_chg = 1'b0;
        end else begin
            m_inq.push_back({bus._EI, bus._I});
            s = m_inq.pop_front();
            c = ref_code(s[8], s[7:0]);
            m_cands.push_back(c);
            if (m_cands.size() > F) void'(m_cands.pop_front());
            stable = (m_cands.size() == F);
            foreach (m_cands[k]) if (m_cands[k] != c) stable = 1'b0;
            if (stable && bus._HOLD && c != m_out) begin
                m_out = c;
                m_chg = 1'b1;
            end else begin
                m_chg = 1'b0;
            end
        end
    endtask

    function automatic logic [5:0] obs();
        return {bus._A, bus._GS, bus._EO, bus.CHG};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check("model", 32'(obs()), 32'({m_out, m_chg}));
    endtask

    initial begin
        RST      = 1'b1;
        bus._I    = 8'($urandom);
        bus._EI   = 1'b0;
        bus._HOLD = 1'b1;

        // 1. Reset, then disabled: nothing may change.
        tick(); tick();
        check("reset_vals", 32'(obs()), 32'(6'b111_1_1_0));
        RST     = 1'b0;
        bus._EI = 1'b1;
        bus._I  = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("disabled_hold", 32'(obs()), 32'(6'b111_1_1_0));
        end

        // 2. Idle: enabled, no requests; load exactly on the 4th edge.
        bus._EI = 1'b0;
        tick(); tick(); tick();
        check("idle_not_yet", 32'(obs()), 32'(6'b111_1_1_0));
        tick();
        check("idle_load", 32'(obs()), 32'(6'b111_1_0_1));
        tick();
        check("idle_chg_once", 32'(obs()), 32'(6'b111_1_0_0));

        // 3. Priority: bits 6 and 4 active -> index 6; then only bit 4.
        bus._I = 8'b1010_1111;
        tick(); tick(); tick();
        check("prio_not_yet", 32'(obs()), 32'(6'b111_1_0_0));
        tick();
        check("prio_6", 32'(obs()), 32'(6'b001_0_1_1));
        tick(); tick();
        bus._I = 8'b1110_1111;
        tick(); tick(); tick();
        check("prio_4_not_yet", 32'(obs()), 32'(6'b001_0_1_0));
        tick();
        check("prio_4", 32'(obs()), 32'(6'b011_0_1_1));

        // 4. Glitch on bit 7 for one cycle, then a held request.
        bus._I = 8'b1010_1111;
        repeat (6) tick();
        check("glitch_base", 32'(obs()), 32'(6'b001_0_1_0));
        bus._I = 8'b0010_1111;
        tick();
        bus._I = 8'b1010_1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("glitch_short", 32'(obs()), 32'(6'b001_0_1_0));
        end
        bus._I  = 8'b0010_1111;
        chg_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chg_cnt += int'(bus.CHG);
        end
        check("glitch_long_chg_cnt", 32'(chg_cnt), 32'd1);
        check("glitch_long_code", 32'(obs()), 32'(6'b000_0_1_0));

        // 5. Hold freezes the outputs; release loads on the next edge.
        bus._I = 8'b1010_1111;
        repeat (6) tick();
        check("hold_base", 32'(obs()), 32'(6'b001_0_1_0));
        bus._HOLD = 1'b0;
        bus._I    = 8'hFE;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_frozen", 32'(obs()), 32'(6'b001_0_1_0));
        end
        bus._HOLD = 1'b1;
        tick();
        check("hold_release", 32'(obs()), 32'(6'b111_0_1_1));
        tick();

        // 6. Reset one edge after an input change, then re-propagation.
        bus._I = 8'b0111_1111;
        tick();
        RST = 1'b1;
        tick();
        check("midrst_vals", 32'(obs()), 32'(6'b111_1_1_0));
        RST = 1'b0;
        for (int k = 0; k < S + F - 1; k++) begin
            tick();
            check("midrst_not_yet", 32'(obs()), 32'(6'b111_1_1_0));
        end
        tick();
        check("midrst_reload", 32'(obs()), 32'(6'b000_0_1_1));

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus._I = 8'hFF;
                    1:       bus._I = ~(8'h01 << $urandom_range(0, 7));
                    default: bus._I = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 15) == 0) bus._EI = ~bus._EI;
            if ($urandom_range(0, 9) == 0) bus._HOLD = ~bus._HOLD;
            RST = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
